cursor_sequencer: RTL and testbench

CURSOR_SEQUENCER -- requirements
Module: cursor_sequencer

---
 rtl/cursor_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_cursor_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_sequencer.sv
// Cursor sequencer: turns a byte stream into text-RAM writes and cursor updates, with scroll-on-newline.
// Optional form-feed full-screen clear is enabled by defining CURSOR_SEQUENCER_FF_CLEAR_EN.
module cursor_sequencer #(
    parameter int unsigned COL_BITS = 7,
    parameter int unsigned ROW_BITS = 5,
    parameter int unsigned COLS     = 80,
    parameter int unsigned ROWS     = 25
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [COL_BITS-1:0] cur_x,
    output logic [ROW_BITS-1:0] cur_y,
    output logic                cur_wen,
    output logic [ROW_BITS-1:0] top_row,
    output logic [ROW_BITS-1:0] ram_addr_row,
    output logic [COL_BITS-1:0] ram_addr_col,
    output logic [7:0]          ram_data,
    output logic                ram_wen,
    output logic                busy
);

    localparam logic [COL_BITS-1:0] LAST_COL   = COL_BITS'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW   = ROW_BITS'(ROWS - 1);
    localparam logic [ROW_BITS:0]   ROWS_W     = (ROW_BITS + 1)'(ROWS);
    localparam logic [ROW_BITS:0]   ROWS_M1_W  = (ROW_BITS + 1)'(ROWS - 1);
    localparam logic [7:0]          CH_SPACE   = 8'h20;
    localparam logic [7:0]          CH_TILDE   = 8'h7E;
    localparam logic [7:0]          CH_CR      = 8'h0D;
    localparam logic [7:0]          CH_LF      = 8'h0A;
    localparam logic [7:0]          CH_BS      = 8'h08;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
    localparam logic [7:0]          CH_FF      = 8'h0C;

    typedef enum logic [1:0] {IDLE, EXEC, CLEAR, CLRALL} state_t;
`else
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;
`endif

    state_t state, state_d;

    logic [COL_BITS-1:0] cur_x_d, ram_addr_col_d;
    logic [ROW_BITS-1:0] cur_y_d, top_row_d, ram_addr_row_d;
    logic [ROW_BITS-1:0] clr_row, clr_row_d;
    logic [7:0]          ram_data_d;
    logic                cur_wen_d, ram_wen_d, busy_d;
    logic                scroll_pend, scroll_pend_d;
    logic                newline;
    logic [ROW_BITS-1:0] phys_row, top_inc, bottom_row;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
    logic                ff_pend, ff_pend_d;
`endif

    // Reduce a value below 2*ROWS into 0..ROWS-1 with one conditional subtract.
    function automatic logic [ROW_BITS-1:0] wrap_row(input logic [ROW_BITS:0] v);
        if (v >= ROWS_W) begin
            return ROW_BITS'(v - ROWS_W);
        end
        return ROW_BITS'(v);
    endfunction

    assign in_ready   = (state == IDLE) && !reset;
    assign phys_row   = wrap_row({1'b0, cur_y} + {1'b0, top_row});
    assign top_inc    = wrap_row({1'b0, top_row} + (ROW_BITS + 1)'(1));
    assign bottom_row = wrap_row({1'b0, top_inc} + ROWS_M1_W);

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d        = state;
        cur_x_d        = cur_x;
        cur_y_d        = cur_y;
        top_row_d      = top_row;
        cur_wen_d      = 1'b0;
        ram_wen_d      = 1'b0;
        ram_addr_row_d = ram_addr_row;
        ram_addr_col_d = ram_addr_col;
        ram_data_d     = ram_data;
        clr_row_d      = clr_row;
        scroll_pend_d  = scroll_pend;
        newline        = 1'b0;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
        ff_pend_d      = ff_pend;
`endif

        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d       = EXEC;
                    scroll_pend_d = 1'b0;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
                    ff_pend_d     = 1'b0;
`endif
                    if (in_data >= CH_SPACE && in_data <= CH_TILDE) begin
                        ram_wen_d      = 1'b1;
                        ram_data_d     = in_data;
                        ram_addr_col_d = cur_x;
                        ram_addr_row_d = phys_row;
                        cur_wen_d      = 1'b1;
                        if (cur_x < LAST_COL) begin
                            cur_x_d = cur_x + COL_BITS'(1);
                        end else begin
                            cur_x_d = '0;
                            newline = 1'b1;
                        end
                    end else if (in_data == CH_CR) begin
                        cur_x_d   = '0;
                        cur_wen_d = 1'b1;
                    end else if (in_data == CH_LF) begin
                        cur_x_d   = '0;
                        newline   = 1'b1;
                        cur_wen_d = 1'b1;
                    end else if (in_data == CH_BS) begin
                        if (cur_x != '0) begin
                            cur_x_d = cur_x - COL_BITS'(1);
                        end
                        cur_wen_d = 1'b1;
                    end
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
                    else if (in_data == CH_FF) begin
                        cur_x_d   = '0;
                        cur_y_d   = '0;
                        top_row_d = '0;
                        cur_wen_d = 1'b1;
                        ff_pend_d = 1'b1;
                    end
`endif

                    // Bottom line scrolls: the row that just left the top becomes the new bottom.
                    if (newline) begin
                        if (cur_y < LAST_ROW) begin
                            cur_y_d = cur_y + ROW_BITS'(1);
                        end else begin
                            top_row_d     = top_inc;
                            clr_row_d     = bottom_row;
                            scroll_pend_d = 1'b1;
                        end
                    end
                end
            end

            EXEC: begin
                if (scroll_pend) begin
                    state_d        = CLEAR;
                    ram_wen_d      = 1'b1;
                    ram_data_d     = CH_SPACE;
                    ram_addr_row_d = clr_row;
                    ram_addr_col_d = '0;
                end
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
                else if (ff_pend) begin
                    state_d        = CLRALL;
                    ram_wen_d      = 1'b1;
                    ram_data_d     = CH_SPACE;
                    ram_addr_row_d = '0;
                    ram_addr_col_d = '0;
                end
`endif
                else begin
                    state_d = IDLE;
                end
            end

            CLEAR: begin
                if (ram_addr_col == LAST_COL) begin
                    state_d = IDLE;
                end else begin
                    ram_wen_d      = 1'b1;
                    ram_addr_col_d = ram_addr_col + COL_BITS'(1);
                end
            end

`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
            CLRALL: begin
                if (ram_addr_col != LAST_COL) begin
                    ram_wen_d      = 1'b1;
                    ram_addr_col_d = ram_addr_col + COL_BITS'(1);
                end else if (ram_addr_row != LAST_ROW) begin
                    ram_wen_d      = 1'b1;
                    ram_addr_col_d = '0;
                    ram_addr_row_d = ram_addr_row + ROW_BITS'(1);
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any in-flight clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cur_x        <= '0;
            cur_y        <= '0;
            top_row      <= '0;
            cur_wen      <= 1'b0;
            ram_wen      <= 1'b0;
            ram_addr_row <= '0;
            ram_addr_col <= '0;
            ram_data     <= '0;
            busy         <= 1'b0;
            clr_row      <= '0;
            scroll_pend  <= 1'b0;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
            ff_pend      <= 1'b0;
`endif
        end else begin
            state        <= state_d;
            cur_x        <= cur_x_d;
            cur_y        <= cur_y_d;
            top_row      <= top_row_d;
            cur_wen      <= cur_wen_d;
            ram_wen      <= ram_wen_d;
            ram_addr_row <= ram_addr_row_d;
            ram_addr_col <= ram_addr_col_d;
            ram_data     <= ram_data_d;
            busy         <= busy_d;
            clr_row      <= clr_row_d;
            scroll_pend  <= scroll_pend_d;
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
            ff_pend      <= ff_pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_cursor_sequencer.sv
// Directed scoreboard bench for cursor_sequencer: a behavioural cursor/screen model predicts
// every RAM write, cursor strobe and busy span for each byte sent.
module tb_cursor_sequencer;

    localparam int COL_BITS = 7;
    localparam int ROW_BITS = 5;
    localparam int COLS     = 80;
    localparam int ROWS     = 25;

    typedef struct packed {
        logic [ROW_BITS-1:0] row;
        logic [COL_BITS-1:0] col;
        logic [7:0]          data;
    } wr_t;

    logic                clk = 1'b0;
    logic                reset;
    logic [7:0]          in_data;
    logic                in_valid;
    logic                in_ready;
    logic [COL_BITS-1:0] cur_x;
    logic [ROW_BITS-1:0] cur_y;
    logic                cur_wen;
    logic [ROW_BITS-1:0] top_row;
    logic [ROW_BITS-1:0] ram_addr_row;
    logic [COL_BITS-1:0] ram_addr_col;
    logic [7:0]          ram_data;
    logic                ram_wen;
    logic                busy;

    int checks = 0;
    int errors = 0;

    wr_t                          exp_wr[$];
    wr_t                          obs_wr[$];
    logic [COL_BITS+ROW_BITS-1:0] exp_cur[$];
    logic [COL_BITS+ROW_BITS-1:0] obs_cur[$];
    int mx, my, mtop;
    int exp_busy, busy_cnt, nrdy_cnt;

    always #5 clk = ~clk;

    cursor_sequencer #(
        .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .COLS(COLS), .ROWS(ROWS)
    ) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .cur_x(cur_x), .cur_y(cur_y), .cur_wen(cur_wen), .top_row(top_row),
        .ram_addr_row(ram_addr_row), .ram_addr_col(ram_addr_col), .ram_data(ram_data),
        .ram_wen(ram_wen), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and record what the DUT presents there.
    task automatic cyc();
        wr_t w;
        @(negedge clk);
        if (ram_wen === 1'b1) begin
            w.row  = ram_addr_row;
            w.col  = ram_addr_col;
            w.data = ram_data;
            obs_wr.push_back(w);
        end
        if (cur_wen === 1'b1) obs_cur.push_back({cur_x, cur_y});
        if (busy === 1'b1) busy_cnt++;
        if (in_ready !== 1'b1) nrdy_cnt++;
    endtask

    task automatic push_wr(input int row, input int col, input logic [7:0] data);
        wr_t w;
        w.row  = ROW_BITS'(row);
        w.col  = COL_BITS'(col);
        w.data = data;
        exp_wr.push_back(w);
    endtask

    // Reference screen model: predicts writes, cursor strobe and busy span for one byte.
    task automatic model_byte(input logic [7:0] b);
        bit nl = 0;
        bit disc = 0;
        bit scr = 0;
        bit ff = 0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr((my + mtop) % ROWS, mx, b);
            if (mx < COLS - 1) mx++;
            else begin mx = 0; nl = 1; end
        end else if (b == 8'h0D) begin
            mx = 0;
        end else if (b == 8'h0A) begin
            mx = 0; nl = 1;
        end else if (b == 8'h08) begin
            if (mx > 0) mx--;
        end
`ifdef CURSOR_SEQUENCER_FF_CLEAR_EN
        else if (b == 8'h0C) begin
            mx = 0; my = 0; mtop = 0; ff = 1;
        end
`endif
        else begin
            disc = 1;
        end
        if (nl) begin
            if (my < ROWS - 1) my++;
            else begin
                mtop = (mtop + 1) % ROWS;
                scr = 1;
                for (int c = 0; c < COLS; c++) push_wr((mtop + ROWS - 1) % ROWS, c, 8'h20);
            end
        end
        if (ff) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) push_wr(r, c, 8'h20);
        end
        if (!disc) exp_cur.push_back({COL_BITS'(mx), ROW_BITS'(my)});
        exp_busy = 1 + (scr ? COLS : 0) + (ff ? ROWS * COLS : 0);
    endtask

    task automatic send(input logic [7:0] b, input string tag);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 20) begin cyc(); n++; end
        chk({tag, " ready"}, 32'(in_ready), 32'd1);
        obs_wr.delete();
        obs_cur.delete();
        busy_cnt = 0;
        nrdy_cnt = 0;
        model_byte(b);
        in_data  = b;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        in_data  = 8'h00;
        n = 0;
        while (busy === 1'b1 && n < ROWS * COLS + 200) begin cyc(); n++; end
        chk({tag, " drained"}, 32'(busy), 32'd0);
        chk({tag, " nwr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
            chk({tag, " wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
        chk({tag, " ncur"}, obs_cur.size(), exp_cur.size());
        for (int i = 0; i < exp_cur.size() && i < obs_cur.size(); i++)
            chk({tag, " curwen"}, 32'(obs_cur[i]), 32'(exp_cur[i]));
        chk({tag, " busy_cycles"}, busy_cnt, exp_busy);
        chk({tag, " notready_cycles"}, nrdy_cnt, exp_busy);
        chk({tag, " cur_x"}, 32'(cur_x), mx);
        chk({tag, " cur_y"}, 32'(cur_y), my);
        chk({tag, " top_row"}, 32'(top_row), mtop);
        exp_wr.delete();
        exp_cur.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();
        mx = 0; my = 0; mtop = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " cur_x"}, 32'(cur_x), 0);
        chk({tag, " cur_y"}, 32'(cur_y), 0);
        chk({tag, " top_row"}, 32'(top_row), 0);
        chk({tag, " cur_wen"}, 32'(cur_wen), 0);
        chk({tag, " ram_wen"}, 32'(ram_wen), 0);
        chk({tag, " ram_row"}, 32'(ram_addr_row), 0);
        chk({tag, " ram_col"}, 32'(ram_addr_col), 0);
        chk({tag, " ram_data"}, 32'(ram_data), 0);
        chk({tag, " busy"}, 32'(busy), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        cyc();
        cyc();
        chk("rst in_ready", 32'(in_ready), 0);
        chk_reset_outputs("rst");
        reset = 1'b0;
        cyc();
        chk("post-rst in_ready", 32'(in_ready), 1);
        mx = 0; my = 0; mtop = 0;

        // Single printable byte from home position.
        send(8'h41, "A");
        chk("A x", 32'(cur_x), 1);
        chk("A notready", nrdy_cnt, 1);
        send(8'h0D, "CR");

        // Reach (79,3) and print into the last column.
        for (int i = 0; i < 3; i++) send(8'h0A, "LF");
        for (int i = 0; i < 79; i++) send(8'(8'h21 + (i % 90)), "fill");
        chk("fill x", 32'(cur_x), 79);
        send(8'h5A, "Z");
        chk("Z x", 32'(cur_x), 0);
        chk("Z y", 32'(cur_y), 4);

        // Down to the bottom line, then scroll on LF.
        for (int i = 0; i < 20; i++) send(8'h0A, "LF");
        for (int i = 0; i < 10; i++) send(8'h61, "a");
        send(8'h0A, "scroll");
        chk("scroll top", 32'(top_row), 1);
        chk("scroll busy", busy_cnt, 81);

        // Form feed: full clear when enabled, discarded otherwise.
        for (int i = 0; i < 5; i++) send(8'h6B, "k");
        send(8'h0C, "FF");

        // Backspace at column 0 and a discarded control byte.
        do_reset();
        for (int i = 0; i < 5; i++) send(8'h0A, "LF");
        send(8'h08, "BS0");
        send(8'h01, "ctl");
        chk("ctl nwr", obs_wr.size(), 0);
        send(8'h6D, "m");
        send(8'h08, "BS1");
        chk("BS1 x", 32'(cur_x), 0);

        // Printable byte in the last cell scrolls via column wrap.
        for (int i = 0; i < 19; i++) send(8'h0A, "LF");
        for (int i = 0; i < 79; i++) send(8'h2E, "dot");
        send(8'h7E, "wrapscroll");

        // Reset in the middle of a scroll clear.
        do_reset();
        for (int i = 0; i < 24; i++) send(8'h0A, "LF");
        in_data  = 8'h0A;
        in_valid = 1'b1;
        cyc();
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) cyc();
        chk("mid-clear ram_wen", 32'(ram_wen), 1);
        chk("mid-clear col", 32'(ram_addr_col), 29);
        reset = 1'b1;
        cyc();
        chk("abort in_ready", 32'(in_ready), 0);
        chk_reset_outputs("abort");
        reset = 1'b0;
        cyc();
        chk("abort ram_wen", 32'(ram_wen), 0);
        chk("abort release in_ready", 32'(in_ready), 1);
        mx = 0; my = 0; mtop = 0;
        send(8'h42, "B");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
